// File: rtl/stream_collector.sv
`default_nettype none
// ============================================================================
//  Module      : stream_collector
//  Description : Packs a stream of DATA_WIDTH items into words of up to
//                ITEM_COUNT slots. A word closes when it is full, when the
//                closing item carries in_last, or (if FLUSH_TIMEOUT > 0) when
//                a partial word has sat idle for FLUSH_TIMEOUT cycles.
//                Storage is an assembly buffer followed by one output
//                register. A completed word that cannot move into the output
//                register is parked as "pending" in the assembly buffer.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock      in   rising-edge clock
//    reset      in   asynchronous active-high reset
//    in_data    in   [DATA_WIDTH]             item
//    in_valid   in   item present
//    in_ready   out  item accepted when in_valid && in_ready
//    in_last    in   item ends the current group
//    out_data   out  [DATA_WIDTH*ITEM_COUNT]  packed word, slot 0 in the LSBs
//    out_count  out  [COUNT_BITS]             number of valid slots (1..N)
//    out_valid  out  word present
//    out_ready  in   word consumed when out_valid && out_ready
//    out_last   out  word ends a group
// ============================================================================
module stream_collector #(
  parameter int DATA_WIDTH    = 8,
  parameter int ITEM_COUNT    = 4,
  parameter int COUNT_BITS    = $clog2(ITEM_COUNT + 1),
  parameter int FLUSH_TIMEOUT = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
  output logic [DATA_WIDTH*ITEM_COUNT-1:0] out_data,
  output logic [COUNT_BITS-1:0]            out_count,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last
);

  localparam int c_FILL_BITS = $clog2(ITEM_COUNT + 1);
  localparam int c_WORD_BITS = DATA_WIDTH * ITEM_COUNT;
  localparam logic [c_FILL_BITS-1:0] c_LAST_SLOT = c_FILL_BITS'(ITEM_COUNT - 1);
  localparam logic [c_FILL_BITS-1:0] c_FILL_ONE  = c_FILL_BITS'(1);

  // --------------------------------------------------------------------------
  // Assembly buffer
  // --------------------------------------------------------------------------
  logic [c_WORD_BITS-1:0] r_asm;      // slots; unused slots are kept at zero
  logic [c_FILL_BITS-1:0] r_fill;     // number of slots written
  logic                   r_last;     // parked word closes a group
  logic                   r_pending;  // assembly holds a completed word

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  logic [c_WORD_BITS-1:0] r_out_data;
  logic [COUNT_BITS-1:0]  r_out_count;
  logic                   r_out_last;
  logic                   r_out_valid;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                   w_accept;       // item handshake this cycle
  logic                   w_out_free;     // output register can take a word
  logic                   w_complete;     // assembly closes a word this cycle
  logic                   w_timeout;      // idle flush fires this cycle
  logic                   w_load;         // output register loads this cycle
  logic [c_WORD_BITS-1:0] w_word;         // assembly including this cycle's item
  logic [c_FILL_BITS-1:0] w_word_count;
  logic                   w_word_last;

  assign in_ready   = !r_pending;
  assign w_accept   = in_valid && !r_pending;
  assign w_out_free = !r_out_valid || out_ready;

  // An accepted item closes the word when it fills the last slot or ends the
  // group. The timeout path can only fire when no item is accepted.
  assign w_complete = (w_accept && ((r_fill == c_LAST_SLOT) || in_last))
                    || w_timeout;

  // A parked word and a freshly completed word are mutually exclusive: while
  // pending, no item is accepted and the idle counter is held at zero.
  assign w_load = (w_complete || r_pending) && w_out_free;

  // Merge the incoming item into slot[fill] so a word completing this cycle
  // can be loaded straight into the output register without a bubble.
  for (genvar gi = 0; gi < ITEM_COUNT; gi++) begin : g_slot
    assign w_word[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH] =
        (w_accept && (r_fill == c_FILL_BITS'(gi)))
        ? in_data
        : r_asm[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH];
  end

  assign w_word_count = w_accept ? (r_fill + c_FILL_ONE) : r_fill;
  assign w_word_last  = r_pending ? r_last : (w_accept && in_last);

  // --------------------------------------------------------------------------
  // Idle flush counter
  // --------------------------------------------------------------------------
  if (FLUSH_TIMEOUT > 0) begin : g_flush
    localparam int c_IDLE_BITS = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [c_IDLE_BITS-1:0] c_IDLE_FIRE = c_IDLE_BITS'(FLUSH_TIMEOUT - 1);
    localparam logic [c_IDLE_BITS-1:0] c_IDLE_ONE  = c_IDLE_BITS'(1);

    logic [c_IDLE_BITS-1:0] r_idle;
    logic                   w_idle;

    // Idle means a partial word sits unparked and no item arrives. fill is
    // always below ITEM_COUNT when not pending, so only the lower bound is
    // tested. An accepted item suppresses the flush in the same cycle.
    assign w_idle    = (r_fill != '0) && !r_pending && !w_accept;
    assign w_timeout = w_idle && (r_idle == c_IDLE_FIRE);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_idle <= '0;
      end else if (w_idle && !w_timeout) begin
        r_idle <= r_idle + c_IDLE_ONE;
      end else begin
        r_idle <= '0;
      end
    end
  end else begin : g_no_flush
    assign w_timeout = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Assembly buffer update
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_asm     <= '0;
      r_fill    <= '0;
      r_last    <= 1'b0;
      r_pending <= 1'b0;
    end else if (w_load) begin
      // Word moves to the output register; restart at slot 0.
      r_asm     <= '0;
      r_fill    <= '0;
      r_last    <= 1'b0;
      r_pending <= 1'b0;
    end else if (w_complete) begin
      // Output register busy: park the finished word in place.
      r_asm     <= w_word;
      r_fill    <= w_word_count;
      r_last    <= w_accept && in_last;
      r_pending <= 1'b1;
    end else if (w_accept) begin
      r_asm     <= w_word;
      r_fill    <= w_word_count;
    end
  end

  // --------------------------------------------------------------------------
  // Output register update
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_word;
      r_out_count <= COUNT_BITS'(w_word_count);
      r_out_last  <= w_word_last;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_collector
//  Description : Self-checking bench for stream_collector (DATA_WIDTH=8,
//                ITEM_COUNT=4, FLUSH_TIMEOUT=3). Directed vector table,
//                hand-written timeout and asynchronous-reset sequences, and
//                a randomized run compared against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stream_collector;

  localparam int c_DW = 8;
  localparam int c_N  = 4;
  localparam int c_TO = 3;
  localparam int c_CB = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [c_DW-1:0]   in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [c_DW*c_N-1:0] out_data;
  logic [c_CB-1:0]   out_count;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;

  stream_collector #(
    .DATA_WIDTH   (c_DW),
    .ITEM_COUNT   (c_N),
    .COUNT_BITS   (c_CB),
    .FLUSH_TIMEOUT(c_TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .out_data (out_data),
    .out_count(out_count),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input bit e_rdy, input bit e_vld,
                           input logic [31:0] e_data, input int e_cnt, input bit e_last);
    check({name, " in_ready"}, 64'(in_ready), 64'(e_rdy));
    check({name, " out_valid"}, 64'(out_valid), 64'(e_vld));
    if (e_vld) begin
      check({name, " out_data"}, 64'(out_data), 64'(e_data));
      check({name, " out_count"}, 64'(out_count), 64'(e_cnt));
      check({name, " out_last"}, 64'(out_last), 64'(e_last));
    end
  endtask

  task automatic send_item(input logic [7:0] d, input bit l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clock);
    #1;
  endtask

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        ordy;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_last;
  } vec_t;

  function automatic vec_t mk(input bit v, input logic [7:0] d, input bit l, input bit ordy,
                              input bit e_rdy, input bit e_vld, input logic [31:0] e_data,
                              input int e_cnt, input bit e_last);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.ordy = ordy;
    r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_data = e_data;
    r.e_cnt = 3'(e_cnt); r.e_last = e_last;
    return r;
  endfunction

  // Reference model state: items of the open word, idle count, parked word,
  // and the word currently presented on the output.
  logic [7:0]  m_items[$];
  int          m_idle;
  bit          m_pend;
  logic [31:0] m_pw;
  int          m_pc;
  bit          m_pl;
  bit          m_ov;
  logic [31:0] m_od;
  int          m_oc;
  bit          m_ol;

  vec_t tbl[25];

  initial begin
    int nwords;
    bit sparse;
    bit acc, free, done, nl;
    logic [31:0] nw;
    int nc;

    // ---------------- vector table ----------------
    tbl[0]  = mk(1, 8'h01, 0, 1,  1, 0, 32'h0, 0, 0);
    tbl[1]  = mk(1, 8'h02, 0, 1,  1, 0, 32'h0, 0, 0);
    tbl[2]  = mk(1, 8'h03, 0, 1,  1, 0, 32'h0, 0, 0);
    tbl[3]  = mk(1, 8'h04, 0, 1,  1, 1, 32'h04030201, 4, 0);
    tbl[4]  = mk(1, 8'h05, 0, 1,  1, 0, 32'h0, 0, 0);
    tbl[5]  = mk(1, 8'h06, 0, 1,  1, 0, 32'h0, 0, 0);
    tbl[6]  = mk(1, 8'h07, 0, 1,  1, 0, 32'h0, 0, 0);
    tbl[7]  = mk(1, 8'h08, 0, 1,  1, 1, 32'h08070605, 4, 0);
    tbl[8]  = mk(0, 8'h00, 0, 1,  1, 0, 32'h0, 0, 0);
    tbl[9]  = mk(1, 8'hAA, 0, 1,  1, 0, 32'h0, 0, 0);
    tbl[10] = mk(1, 8'hBB, 1, 1,  1, 1, 32'h0000BBAA, 2, 1);
    tbl[11] = mk(1, 8'h01, 0, 1,  1, 0, 32'h0, 0, 0);
    tbl[12] = mk(1, 8'h02, 1, 1,  1, 1, 32'h00000201, 2, 1);
    tbl[13] = mk(0, 8'h00, 0, 1,  1, 0, 32'h0, 0, 0);
    tbl[14] = mk(1, 8'h11, 0, 0,  1, 0, 32'h0, 0, 0);
    tbl[15] = mk(1, 8'h12, 0, 0,  1, 0, 32'h0, 0, 0);
    tbl[16] = mk(1, 8'h13, 0, 0,  1, 0, 32'h0, 0, 0);
    tbl[17] = mk(1, 8'h14, 0, 0,  1, 1, 32'h14131211, 4, 0);
    tbl[18] = mk(1, 8'h15, 0, 0,  1, 1, 32'h14131211, 4, 0);
    tbl[19] = mk(1, 8'h16, 0, 0,  1, 1, 32'h14131211, 4, 0);
    tbl[20] = mk(1, 8'h17, 0, 0,  1, 1, 32'h14131211, 4, 0);
    tbl[21] = mk(1, 8'h18, 0, 0,  0, 1, 32'h14131211, 4, 0);
    tbl[22] = mk(1, 8'h99, 0, 0,  0, 1, 32'h14131211, 4, 0);
    tbl[23] = mk(0, 8'h00, 0, 1,  1, 1, 32'h18171615, 4, 0);
    tbl[24] = mk(0, 8'h00, 0, 1,  1, 0, 32'h0, 0, 0);

    // ---------------- reset state ----------------
    #12;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_count", 64'(out_count), 64'd0);
    check("reset out_last", 64'(out_last), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;

    // ---------------- directed table ----------------
    for (int i = 0; i < 25; i++) begin
      in_valid  = tbl[i].v;
      in_data   = tbl[i].d;
      in_last   = tbl[i].l;
      out_ready = tbl[i].ordy;
      @(posedge clock);
      #1;
      check_out($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_vld,
                tbl[i].e_data, int'(tbl[i].e_cnt), tbl[i].e_last);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    // ---------------- idle flush ----------------
    out_ready = 1'b1;
    send_item(8'h11, 0);
    in_valid = 1'b0;
    check_out("to1 c0", 1, 0, 32'h0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clock);
      #1;
      if (c == 3) check_out("to1 flush", 1, 1, 32'h00000011, 1, 0);
      else        check_out($sformatf("to1 c%0d", c), 1, 0, 32'h0, 0, 0);
    end

    // Item arriving on the timeout cycle is packed instead of flushing.
    send_item(8'h22, 0);
    in_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clock);
      #1;
      check_out($sformatf("to2 c%0d", c), 1, 0, 32'h0, 0, 0);
    end
    send_item(8'h33, 0);
    in_valid = 1'b0;
    check_out("to2 c3 no flush", 1, 0, 32'h0, 0, 0);
    for (int c = 4; c <= 7; c++) begin
      @(posedge clock);
      #1;
      if (c == 6) check_out("to2 flush", 1, 1, 32'h00003322, 2, 0);
      else        check_out($sformatf("to2 c%0d", c), 1, 0, 32'h0, 0, 0);
    end

    // ---------------- asynchronous reset mid-operation ----------------
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) send_item(8'(k), 0);
    in_valid = 1'b0;
    check_out("rst held word", 1, 1, 32'h04030201, 4, 0);
    #2;
    reset = 1'b1;
    #1;
    check("rst async out_valid", 64'(out_valid), 64'd0);
    check("rst async out_data", 64'(out_data), 64'd0);
    check("rst async out_count", 64'(out_count), 64'd0);
    check("rst async in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    nwords = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) begin
        in_valid = 1'b1;
        in_data  = 8'(c + 1);
        in_last  = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clock);
      #1;
      if (out_valid) begin
        nwords++;
        check("rst after word", 64'(out_data), 64'h04030201);
      end
    end
    check("rst word count", 64'(nwords), 64'd1);

    // ---------------- randomized run vs reference model ----------------
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    m_items.delete();
    m_idle = 0; m_pend = 0; m_pw = '0; m_pc = 0; m_pl = 0;
    m_ov = 0; m_od = '0; m_oc = 0; m_ol = 0;
    sparse = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd in_ready", 64'(in_ready), 64'(!m_pend));
      check("rnd out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        check("rnd out_data", 64'(out_data), 64'(m_od));
        check("rnd out_count", 64'(out_count), 64'(m_oc));
        check("rnd out_last", 64'(out_last), 64'(m_ol));
      end

      if (cyc % 64 == 0) sparse = ($urandom_range(0, 1) == 1);
      in_valid  = sparse ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 9) < 6);

      // Model: close words by count, group end or idle time; deliver in order.
      free = !m_ov || out_ready;
      acc  = in_valid && !m_pend;
      done = 0;
      nl   = 0;
      if (acc) begin
        m_items.push_back(in_data);
        m_idle = 0;
        if (m_items.size() == c_N || in_last) begin
          done = 1;
          nl   = in_last;
        end
      end else if (!m_pend && m_items.size() > 0) begin
        m_idle++;
        if (m_idle == c_TO) done = 1;
      end else begin
        m_idle = 0;
      end
      nw = '0;
      nc = 0;
      if (done) begin
        for (int j = 0; j < m_items.size(); j++) nw = nw | (32'(m_items[j]) << (8 * j));
        nc = m_items.size();
        m_items.delete();
        m_idle = 0;
      end
      if (m_pend && free) begin
        m_ov = 1; m_od = m_pw; m_oc = m_pc; m_ol = m_pl; m_pend = 0;
      end else if (done && free) begin
        m_ov = 1; m_od = nw; m_oc = nc; m_ol = nl;
      end else begin
        if (done) begin
          m_pend = 1; m_pw = nw; m_pc = nc; m_pl = nl;
        end
        if (m_ov && out_ready) m_ov = 0;
      end

      @(posedge clock);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
